round_robin_arbiter: RTL and testbench
======================================

# round_robin_arbiter

Round-robin arbiter that shares one resource among W requesters. It turns a request vector into a registered, one-hot grant that the owner holds until it releases. Rotating priority guarantees fairness: the search for the next owner starts at the requester after the last owner and wraps around. It sits in front of the shared datapath and drives its select/enable, in place of a fixed-priority encoder.

## Interface
Parameters:
- W, 4: number of requesters; legal range W ≥ 2.
- MAX_HOLD, 16: maximum grant tenure in cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range MAX_HOLD ≥ 1.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  synchronous, active-low reset.
- request_vec  input  W  bit i high means requester i wants the resource.
- release  input  1  the current owner is done; sampled only while grant_valid=1.
- grant_vec  output  W  one-hot grant, registered; all zeros when no owner.
- granted_idx  output  $clog2(W)  index of the current owner, registered; 0 when no owner.
- grant_valid  output  1  high while grant_vec is nonzero.
- error  output  1  one-cycle pulse after release is sampled while grant_valid=0.
- timeout  output  1  one-cycle pulse after a forced revocation; tied 0 without ARB_TIMEOUT_EN.

## Operation
- State: FSM {IDLE, GRANTED}, rotation pointer ptr (width $clog2(W)), hold counter hold_cnt (width $clog2(MAX_HOLD+1), macro only).
- Reset (reset_L=0 at an edge):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant_vec=0, granted_idx=0, grant_valid=0, error=0, timeout=0.
  - Reset overrides everything, including a grant in progress.
- Winner selection:
  - The winner is the lowest index k ≥ ptr with request_vec[k]=1.
  - If there is none, the search wraps to the lowest k < ptr with request_vec[k]=1.
  - If request_vec=0, there is no winner.
- IDLE:
  - Winner exists: grant it at the edge, go to GRANTED, hold_cnt=0.
  - Otherwise: stay in IDLE.
- GRANTED, end-of-tenure condition. Any one of the following:
  - release=1;
  - request_vec[granted_idx]=0 (implicit release; not an error);
  - timeout (macro only).
- GRANTED, actions at the edge where end-of-tenure holds:
  - ptr ← (granted_idx+1) mod W.
  - Winner selection runs with the updated ptr value, applied combinationally in the same cycle.
  - Winner exists: grant it at the same edge (zero-bubble handoff). It may be the same requester if that requester is the only one still asserting.
  - No winner: go to IDLE, grant outputs cleared.
- GRANTED, no end-of-tenure: grant held unchanged, hold_cnt increments.
- Grant changes only at tenure boundaries. Requests arriving mid-tenure never preempt the owner.
- error: registered, equals release AND NOT grant_valid from the previous cycle; has no effect on the FSM.

## Timing
- Latency from request to grant: 1 cycle. A request sampled at edge n produces grant outputs valid after edge n.
- A tenure lasts at least 1 cycle. Release sampled at the first grant cycle ends the tenure at the next edge.
- Release in cycle n: the new owner, or no owner, is visible after edge n. There is no idle cycle between owners.
- grant_vec, granted_idx and grant_valid always update at the same edge and stay mutually consistent.
- Simultaneous release and a new request from the owner: the owner is re-granted only if no other requester is found between ptr and the wrap back to the owner.

## Configuration
- ARB_TIMEOUT_EN defined:
  - hold_cnt resets to 0 on every new grant, including a re-grant to the same owner.
  - A tenure that reaches MAX_HOLD cycles without release ends at that edge.
  - timeout=1 for the following cycle.
  - The grant is at most MAX_HOLD cycles long.
- ARB_TIMEOUT_EN undefined:
  - No counter is built, timeout is constant 0, MAX_HOLD is ignored.
  - A grant is held indefinitely until release or the owner's request drops.

## Test plan
- Reset: reset_L=0 for 2 cycles with request_vec=4'b1111 → all outputs 0. After reset_L=1, granted_idx=0 one cycle later. Assert reset_L=0 mid-tenure → outputs 0 after that edge.
- Rotation: request_vec=4'b1111, release pulsed in every grant cycle → granted_idx 0,1,2,3,0 on consecutive cycles, grant_valid continuously 1.
- Wrap: after owner 1 releases with request_vec=4'b1001 → granted_idx=3, then 0. Drop all requests → grant_valid=0, IDLE.
- Sole requester: request_vec=4'b0100 held, release every 3rd cycle → granted_idx=2 continuously with no bubble. Drop request bit 2 → grant_vec=0 next cycle, error=0.
- Protocol: release=1 while grant_valid=0 → error=1 for exactly one cycle, no grant issued.
- Timeout, MAX_HOLD=4, request_vec=4'b0011, no release:
  - With ARB_TIMEOUT_EN: idx 0 held exactly 4 cycles, then timeout=1 for one cycle and idx 1 granted.
  - Without ARB_TIMEOUT_EN: idx 0 held for 100 cycles, timeout=0 throughout.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until release, with rotating priority.
// Optional forced revocation after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module round_robin_arbiter #(
   parameter int W        = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clock,
   input  logic                 reset_L,
   input  logic [W-1:0]         request_vec,
   input  logic                 release_i,
   output logic [W-1:0]         grant_vec,
   output logic [$clog2(W)-1:0] granted_idx,
   output logic                 grant_valid,
   output logic                 error,
   output logic                 timeout
);

   localparam int IW = $clog2(W);

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
   logic [IW-1:0]   next_ptr, base, win;
   logic [W-1:0]    gvec_q, gvec_d;
   logic            valid_q, valid_d, error_q;
   logic            any_req, end_ten, grant_new, hold_hit;

   // Lowest requester at or above start, otherwise the lowest one overall (wrap).
   function automatic logic [IW-1:0] pick(input logic [W-1:0] req, input logic [IW-1:0] start);
      logic [IW-1:0] hi, lo;
      logic          hit_hi;
      hi     = '0;
      lo     = '0;
      hit_hi = 1'b0;
      for (int k = W - 1; k >= 0; k--) begin
         if (req[k]) begin
            lo = IW'(k);
            if (k >= int'(start)) begin
               hi     = IW'(k);
               hit_hi = 1'b1;
            end
         end
      end
      return hit_hi ? hi : lo;
   endfunction

`ifdef ARB_TIMEOUT_EN
   localparam int HC_W = $clog2(MAX_HOLD + 1);
   logic [HC_W-1:0] hold_q, hold_d;
   logic            timeout_q;

   assign hold_hit = (hold_q == HC_W'(MAX_HOLD - 1));
`else
   assign hold_hit = 1'b0;
`endif

   assign any_req  = |request_vec;
   assign next_ptr = (idx_q == IW'(W - 1)) ? '0 : idx_q + 1'b1;
   assign end_ten  = (state_q == GRANTED) &&
                     (release_i || !request_vec[idx_q] || hold_hit);
   // The pointer advance is visible to the search in the same cycle for zero-bubble handoff.
   assign base     = end_ten ? next_ptr : ptr_q;
   assign win      = pick(request_vec, base);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      gvec_d    = gvec_q;
      valid_d   = valid_q;
      grant_new = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d   = GRANTED;
               grant_new = 1'b1;
            end
         end
         GRANTED: begin
            if (end_ten) begin
               ptr_d = next_ptr;
               if (any_req) begin
                  grant_new = 1'b1;
               end else begin
                  state_d = IDLE;
                  idx_d   = '0;
                  gvec_d  = '0;
                  valid_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (grant_new) begin
         idx_d   = win;
         gvec_d  = W'(1) << win;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_L) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         gvec_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         gvec_q  <= gvec_d;
         valid_q <= valid_d;
         error_q <= release_i & ~valid_q;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_comb begin
      hold_d = hold_q;
      if (grant_new) begin
         hold_d = '0;
      end else if (state_q == GRANTED) begin
         hold_d = hold_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_L) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= (state_q == GRANTED) && hold_hit && !release_i && request_vec[idx_q];
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign grant_vec   = gvec_q;
   assign granted_idx = idx_q;
   assign grant_valid = valid_q;
   assign error       = error_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench for round_robin_arbiter: a queue-based reference model predicts every cycle,
// an independent monitor pops and compares on the falling edge.
module tb_round_robin_arbiter;

   localparam int W  = 4;
   localparam int MH = 4;
   localparam int IW = $clog2(W);
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset_L;
   logic [W-1:0]  request_vec;
   logic          release_i;
   logic [W-1:0]  grant_vec;
   logic [IW-1:0] granted_idx;
   logic          grant_valid;
   logic          error;
   logic          timeout;

   round_robin_arbiter #(.W(W), .MAX_HOLD(MH)) dut (
      .clock       (clock),
      .reset_L     (reset_L),
      .request_vec (request_vec),
      .release_i   (release_i),
      .grant_vec   (grant_vec),
      .granted_idx (granted_idx),
      .grant_valid (grant_valid),
      .error       (error),
      .timeout     (timeout)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [W-1:0]  gv;
      logic [IW-1:0] idx;
      logic          v;
      logic          e;
      logic          t;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: owner (-1 = none), rotation start, cycles shown so far in this tenure.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;

   function automatic int search(input logic [W-1:0] req, input int p);
      for (int o = 0; o < W; o++) begin
         int k;
         k = (p + o) % W;
         if (((req >> k) & W'(1)) != '0) return k;
      end
      return -1;
   endfunction

   task automatic step(input logic [W-1:0] req, input logic rel, input logic rstn);
      exp_t e;
      logic err, to, own_req, lim;
      request_vec = req;
      release_i   = rel;
      reset_L     = rstn;
      err = rel && (m_owner < 0);
      to  = 1'b0;
      if (!rstn) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
         err     = 1'b0;
      end else if (m_owner < 0) begin
         m_owner = search(req, m_ptr);
         if (m_owner >= 0) m_hold = 1;
      end else begin
         own_req = ((req >> m_owner) & W'(1)) != '0;
         lim     = TO_EN && (m_hold >= MH);
         if (rel || !own_req || lim) begin
            to      = lim && !rel && own_req;
            m_ptr   = (m_owner + 1) % W;
            m_owner = search(req, m_ptr);
            m_hold  = 1;
         end else begin
            m_hold++;
         end
      end
      e.gv  = (m_owner >= 0) ? (W'(1) << m_owner) : '0;
      e.idx = (m_owner >= 0) ? IW'(m_owner) : '0;
      e.v   = (m_owner >= 0);
      e.e   = err;
      e.t   = to;
      @(posedge clock);
      q.push_back(e);
      #1;
   endtask

   // Monitor: one expected entry per clock edge, compared mid-cycle.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clock);
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = {grant_vec, granted_idx, grant_valid, error, timeout};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs cyc=%0d got gv=%b idx=%0d v=%b err=%b to=%b want gv=%b idx=%0d v=%b err=%b to=%b",
                        cyc, a.gv, a.idx, a.v, a.e, a.t, e.gv, e.idx, e.v, e.e, e.t);
            end
         end
      end
   end

   initial begin
      int guard;
      reset_L     = 1'b0;
      request_vec = '0;
      release_i   = 1'b0;

      // reset with all requesting, then first grant
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b1);
      // rotation with release every cycle
      repeat (8) step(4'b1111, 1'b1, 1'b1);
      // reset mid-tenure
      step(4'b1111, 1'b0, 1'b1);
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b1);
      // wrap: owner 1 releases with 1001 pending
      step(4'b1111, 1'b1, 1'b1);
      step(4'b1001, 1'b1, 1'b1);
      step(4'b1001, 1'b1, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      // sole requester re-granted, then implicit release
      for (int i = 0; i < 9; i++) step(4'b0100, (i % 3) == 2, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      // protocol error
      step(4'b0000, 1'b1, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      // long tenure without release
      repeat (100) step(4'b0011, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      // randomized traffic with occasional reset
      for (int i = 0; i < 1500; i++) begin
         logic [W-1:0] r;
         logic         rel, rn;
         r   = W'($urandom);
         rel = ($urandom_range(0, 2) == 0);
         rn  = ($urandom_range(0, 63) != 0);
         step(r, rel, rn);
      end

      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         @(posedge clock);
         guard++;
      end
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
